// File: rtl/memory_pipe_be_if.sv
// Request/response bus for memory_pipe_be.
// slave = memory side, master = bus initiator side.
interface memory_pipe_be_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int WIDTH      = 32,
    parameter int BE_WIDTH   = WIDTH / 8
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [WIDTH-1:0]      req_wdata_i;
    logic [BE_WIDTH-1:0]   req_be_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [WIDTH-1:0]      rsp_rdata_o;
    logic                  rsp_err_o;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i,
        input  req_wdata_i, req_be_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o,
        output rsp_rdata_o, rsp_err_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i,
        output req_wdata_i, req_be_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o,
        input  rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/memory_pipe_be.sv
// Single-port byte-enabled memory with latency pipe,
// in-order response FIFO, credit flow control and clear FSM.
module memory_pipe_be #(
    parameter int DEPTH      = 64,
    parameter int WIDTH      = 32,
    parameter int BE_WIDTH   = WIDTH / 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int RD_LAT     = 1,
    parameter bit CLR_ON_RST = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    memory_pipe_be_if.slave bus,
    output logic            init_done_o
);
    // FIFO depth equals the credit limit, so it can never overflow.
    localparam int FDEPTH = RD_LAT + 1;
    localparam int CW     = $clog2(FDEPTH + 1);
    localparam int PW     = $clog2(FDEPTH);
    localparam int EW     = WIDTH + 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t                state;
    state_t                state_n;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  clr_last;

    logic [WIDTH-1:0]      mem [DEPTH];

    logic                  rdy;
    logic                  acc;
    logic                  addr_err;
    logic                  wr_en;
    logic [WIDTH-1:0]      rd_word;
    logic [EW-1:0]         entry;

    logic                  push;
    logic [EW-1:0]         push_d;
    logic                  pop;
    logic [EW-1:0]         fifo [FDEPTH];
    logic [EW-1:0]         head;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         fcnt;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_n;
    logic                  rsp_vld;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign clr_last = (clr_addr == ADDR_WIDTH'(DEPTH - 1));
    assign acc      = bus.req_valid_i && rdy;
    assign addr_err = 32'(bus.req_addr_i) >= DEPTH;
    assign wr_en    = acc && bus.req_we_i && !addr_err && rst_ni;
    assign entry    = {addr_err, rd_word};

    // Read word sampled at the accepting edge; zero for writes and errors.
    always_comb begin
        rd_word = '0;
        if (!bus.req_we_i && !addr_err)
            rd_word = mem[bus.req_addr_i];
    end

    // Next state: leave INIT once the last word has been cleared.
    always_comb begin
        state_n = state;
        unique case (state)
            INIT: if (clr_last) state_n = RUN;
            RUN:  state_n = RUN;
        endcase
    end

    // State register and clear-address sweep.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= CLR_ON_RST ? INIT : RUN;
            clr_addr <= '0;
        end else begin
            state <= state_n;
            if (state == INIT)
                clr_addr <= clr_addr + 1'b1;
        end
    end

    // Storage: clear sweep in INIT, byte-masked writes in RUN.
    always_ff @(posedge clk_i) begin
        if (rst_ni && state == INIT) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < BE_WIDTH; b++)
                if (bus.req_be_i[b])
                    mem[bus.req_addr_i][8*b +: 8] <= bus.req_wdata_i[8*b +: 8];
        end
    end

    // Outstanding-request count after this cycle's accept and pop.
    always_comb begin
        cnt_n = cnt;
        if (acc && !pop)
            cnt_n = cnt + 1'b1;
        else if (!acc && pop)
            cnt_n = cnt - 1'b1;
    end

    // Credits, registered ready and init-done flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt         <= '0;
            rdy         <= 1'b0;
            init_done_o <= 1'b0;
        end else begin
            cnt         <= cnt_n;
            rdy         <= (state_n == RUN) && (cnt_n < CW'(FDEPTH));
            init_done_o <= (state_n == RUN);
        end
    end

    generate
        if (RD_LAT == 1) begin : g_direct
            assign push   = acc;
            assign push_d = entry;
        end else begin : g_pipe
            logic [RD_LAT-2:0] sv;
            logic [EW-1:0]     sd [RD_LAT-1];

            // Delay line carrying accepted entries to the FIFO.
            always_ff @(posedge clk_i) begin
                sd[0] <= entry;
                for (int i = 1; i < RD_LAT - 1; i++)
                    sd[i] <= sd[i-1];
                if (!rst_ni) begin
                    sv <= '0;
                end else begin
                    sv[0] <= acc;
                    for (int i = 1; i < RD_LAT - 1; i++)
                        sv[i] <= sv[i-1];
                end
            end

            assign push   = sv[RD_LAT-2];
            assign push_d = sd[RD_LAT-2];
        end
    endgenerate

    assign pop     = rsp_vld && bus.rsp_ready_i;
    assign rsp_vld = (fcnt != '0);
    assign head    = fifo[rd_ptr];

    // In-order response FIFO; the head holds while stalled.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= push_d;
                wr_ptr       <= nxt(wr_ptr);
            end
            if (pop)
                rd_ptr <= nxt(rd_ptr);
            case ({push, pop})
                2'b10:   fcnt <= fcnt + 1'b1;
                2'b01:   fcnt <= fcnt - 1'b1;
                default: fcnt <= fcnt;
            endcase
        end
    end

    assign bus.req_ready_o = rdy;
    assign bus.rsp_valid_o = rsp_vld;
    assign bus.rsp_rdata_o = rsp_vld ? head[WIDTH-1:0] : '0;
    assign bus.rsp_err_o   = rsp_vld ? head[WIDTH] : 1'b0;
endmodule

// File: tb/tb_memory_pipe_be.sv
// Bench for memory_pipe_be: DUT A (64 words, latency 1) and
// DUT B (48 words, latency 2) against a queue/array model.
module tb_memory_pipe_be;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    memory_pipe_be_if #(.ADDR_WIDTH(AW), .WIDTH(32), .BE_WIDTH(4)) a_if ();
    memory_pipe_be_if #(.ADDR_WIDTH(AW), .WIDTH(32), .BE_WIDTH(4)) b_if ();
    logic a_done, b_done;

    memory_pipe_be #(.DEPTH(64), .WIDTH(32), .RD_LAT(1), .CLR_ON_RST(1'b1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(a_if), .init_done_o(a_done));
    memory_pipe_be #(.DEPTH(48), .WIDTH(32), .RD_LAT(2), .CLR_ON_RST(1'b1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .bus(b_if), .init_done_o(b_done));

    bit          sel = 1'b0;
    logic        valid = 1'b0;
    logic        we = 1'b0;
    logic        rsp_ready = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    bit          rnd_ready = 1'b0;

    assign a_if.req_valid_i = valid && !sel;
    assign a_if.req_we_i    = we;
    assign a_if.req_addr_i  = addr;
    assign a_if.req_wdata_i = wdata;
    assign a_if.req_be_i    = be;
    assign a_if.rsp_ready_i = sel ? 1'b1 : rsp_ready;
    assign b_if.req_valid_i = valid && sel;
    assign b_if.req_we_i    = we;
    assign b_if.req_addr_i  = addr;
    assign b_if.req_wdata_i = wdata;
    assign b_if.req_be_i    = be;
    assign b_if.rsp_ready_i = sel ? rsp_ready : 1'b1;

    function automatic logic o_rdy();
        return sel ? b_if.req_ready_o : a_if.req_ready_o;
    endfunction
    function automatic logic o_rvalid();
        return sel ? b_if.rsp_valid_o : a_if.rsp_valid_o;
    endfunction
    function automatic logic [31:0] o_rdata();
        return sel ? b_if.rsp_rdata_o : a_if.rsp_rdata_o;
    endfunction
    function automatic logic o_err();
        return sel ? b_if.rsp_err_o : a_if.rsp_err_o;
    endfunction

    int errors = 0;
    int checks = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } rsp_t;

    logic [31:0] mm [2][64];
    rsp_t        exp_q [$];
    int          cyc = 0;
    int          acc_cyc [$];
    int          hs_cyc [$];
    bit          last_acc;
    logic [31:0] last_d;
    logic        last_e;
    bit          held = 1'b0;
    logic [31:0] held_d;
    logic        held_e;

    // One clock: model the handshakes that happen at the coming edge.
    task automatic step();
        rsp_t r;
        bit   a;
        bit   h;
        int   dp;
        if (rnd_ready)
            rsp_ready = ($urandom_range(0, 3) != 0);
        if (held) begin
            chk("hold_valid", o_rvalid(), 1);
            chk("hold_rdata", o_rdata(), held_d);
            chk("hold_err", o_err(), held_e);
        end
        a = rst_n && valid && o_rdy();
        h = rst_n && o_rvalid() && rsp_ready;
        held   = rst_n && o_rvalid() && !rsp_ready;
        held_d = o_rdata();
        held_e = o_err();
        if (h) begin
            last_d = o_rdata();
            last_e = o_err();
            hs_cyc.push_back(cyc);
            chk("rsp_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                chk("rsp_rdata", o_rdata(), r.d);
                chk("rsp_err", o_err(), r.e);
            end
        end
        if (a) begin
            dp  = sel ? 48 : 64;
            r.e = int'(addr) >= dp;
            r.d = (we || r.e) ? 32'h0 : mm[sel][addr];
            if (we && !r.e)
                for (int b = 0; b < 4; b++)
                    if (be[b]) mm[sel][addr][8*b +: 8] = wdata[8*b +: 8];
            exp_q.push_back(r);
            acc_cyc.push_back(cyc);
        end
        if (!rst_n) exp_q.delete();
        last_acc = a;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(int n);
        int ta;
        int tb;
        bit ok;
        rst_n = 1'b0;
        valid = 1'b0;
        repeat (n) step();
        chk("rst_a_flags", {a_if.req_ready_o, a_if.rsp_valid_o, a_if.rsp_err_o, a_done}, 0);
        chk("rst_a_rdata", a_if.rsp_rdata_o, 0);
        chk("rst_b_flags", {b_if.req_ready_o, b_if.rsp_valid_o, b_if.rsp_err_o, b_done}, 0);
        chk("rst_b_rdata", b_if.rsp_rdata_o, 0);
        rst_n = 1'b1;
        ta = -1;
        tb = -1;
        ok = 1'b1;
        for (int k = 1; k <= 100 && (ta < 0 || tb < 0); k++) begin
            step();
            if (ta < 0 && a_done) ta = k;
            if (tb < 0 && b_done) tb = k;
            if (a_if.req_ready_o !== a_done || b_if.req_ready_o !== b_done
                || a_if.rsp_valid_o || b_if.rsp_valid_o)
                ok = 1'b0;
        end
        chk("init_cycles_a", ta, 64);
        chk("init_cycles_b", tb, 48);
        chk("ready_tracks_done", ok, 1);
        foreach (mm[i, j]) mm[i][j] = '0;
    endtask

    task automatic issue(bit s, bit w, int a, logic [31:0] d, logic [3:0] b);
        int n;
        sel = s;
        we = w;
        addr = AW'(a);
        wdata = d;
        be = b;
        valid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_acc && n < 50);
        valid = 1'b0;
        chk("accepted", last_acc, 1);
    endtask

    task automatic drain();
        int n;
        valid = 1'b0;
        rnd_ready = 1'b0;
        rsp_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic rand_phase(bit s, int lo, int n);
        sel = s;
        rnd_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0)
                step();
            else
                issue(s, 1'($urandom_range(0, 1)), lo + int'($urandom_range(0, 15)),
                      $urandom, 4'($urandom));
        end
        drain();
    endtask

    typedef struct {
        bit          s;
        bit          w;
        int          a;
        logic [31:0] d;
        logic [3:0]  b;
        logic [31:0] xd;
        bit          xe;
    } vec_t;

    vec_t tv [17];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt_acc;
        int idx;
        int al [4];

        tv[0]  = '{0, 0, 5,  32'h0,        4'h0, 32'h0,        0};
        tv[1]  = '{0, 1, 3,  32'hAABBCCDD, 4'hF, 32'h0,        0};
        tv[2]  = '{0, 1, 3,  32'h11223344, 4'h5, 32'h0,        0};
        tv[3]  = '{0, 0, 3,  32'h0,        4'h0, 32'hAA22CC44, 0};
        tv[4]  = '{0, 1, 63, 32'hDEADBEEF, 4'hC, 32'h0,        0};
        tv[5]  = '{0, 0, 63, 32'h0,        4'h0, 32'hDEAD0000, 0};
        tv[6]  = '{0, 1, 0,  32'h12345678, 4'h0, 32'h0,        0};
        tv[7]  = '{0, 0, 0,  32'h0,        4'h0, 32'h0,        0};
        tv[8]  = '{0, 1, 1,  32'h01020304, 4'hF, 32'h0,        0};
        tv[9]  = '{0, 0, 1,  32'h0,        4'h0, 32'h01020304, 0};
        tv[10] = '{1, 1, 50, 32'hFFFFFFFF, 4'hF, 32'h0,        1};
        tv[11] = '{1, 0, 50, 32'h0,        4'h0, 32'h0,        1};
        tv[12] = '{1, 1, 47, 32'hCAFEF00D, 4'hF, 32'h0,        0};
        tv[13] = '{1, 0, 47, 32'h0,        4'h0, 32'hCAFEF00D, 0};
        tv[14] = '{1, 0, 63, 32'h0,        4'h0, 32'h0,        1};
        tv[15] = '{1, 1, 47, 32'h0,        4'h2, 32'h0,        0};
        tv[16] = '{1, 0, 47, 32'h0,        4'h0, 32'hCAFE000D, 0};

        do_reset(2);

        foreach (tv[i]) begin
            issue(tv[i].s, tv[i].w, tv[i].a, tv[i].d, tv[i].b);
            drain();
            chk($sformatf("vec%0d_rdata", i), last_d, tv[i].xd);
            chk($sformatf("vec%0d_err", i), last_e, tv[i].xe);
        end

        for (int i = 0; i < 8; i++)
            issue(1, 1, i, 32'h11111111 * (i + 1), 4'hF);
        drain();
        acc_cyc.delete();
        hs_cyc.delete();
        sel = 1'b1;
        we = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int n;
            addr = AW'(i);
            n = 0;
            do begin
                step();
                n++;
            end while (!last_acc && n < 20);
        end
        valid = 1'b0;
        drain();
        chk("b2b_acc_count", acc_cyc.size(), 8);
        chk("b2b_rsp_count", hs_cyc.size(), 8);
        if (acc_cyc.size() == 8 && hs_cyc.size() == 8)
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("b2b_acc%0d", i), acc_cyc[i] - acc_cyc[0], i);
                chk($sformatf("b2b_rsp%0d", i), hs_cyc[i] - acc_cyc[0], 2 + i);
            end

        for (int i = 0; i < 48; i++)
            issue(1, 0, i, 32'h0, 4'h0);
        drain();

        al = '{3, 63, 5, 7};
        sel = 1'b0;
        we = 1'b0;
        rsp_ready = 1'b0;
        valid = 1'b1;
        cnt_acc = 0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            addr = AW'(al[idx]);
            step();
            if (last_acc) begin
                cnt_acc++;
                if (idx < 3) idx++;
            end
        end
        chk("stall_accepts", cnt_acc, 2);
        chk("stall_ready", o_rdy(), 0);
        chk("stall_valid", o_rvalid(), 1);
        chk("stall_rdata", o_rdata(), 32'hAA22CC44);
        hs_cyc.delete();
        rsp_ready = 1'b1;
        begin
            int n;
            n = 0;
            do begin
                step();
                n++;
            end while (!last_acc && n < 20);
        end
        valid = 1'b0;
        drain();
        chk("stall_drain_count", hs_cyc.size(), 3);

        rsp_ready = 1'b0;
        issue(0, 0, 3, 32'h0, 4'h0);
        issue(0, 0, 5, 32'h0, 4'h0);
        hs_cyc.delete();
        do_reset(1);
        rsp_ready = 1'b1;
        repeat (5) step();
        chk("no_stale_valid", o_rvalid(), 0);
        chk("no_stale_hs", hs_cyc.size(), 0);

        rand_phase(0, 0, 300);
        rand_phase(1, 40, 300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
